// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants and the decode/issue bundles
// shared by the D-to-E issue path and the ALU.
package mips_isa_pkg;

  localparam logic [4:0] ALUOP_OR   = 5'b00000;
  localparam logic [4:0] ALUOP_ADD  = 5'b00001;
  localparam logic [4:0] ALUOP_SUB  = 5'b00010;
  localparam logic [4:0] ALUOP_LUI  = 5'b00011;
  localparam logic [4:0] ALUOP_SLL  = 5'b00100;
  localparam logic [4:0] ALUOP_XOR  = 5'b00101;
  localparam logic [4:0] ALUOP_SRL  = 5'b00110;
  localparam logic [4:0] ALUOP_SRA  = 5'b00111;
  localparam logic [4:0] ALUOP_AND  = 5'b01000;
  localparam logic [4:0] ALUOP_NOR  = 5'b01001;
  localparam logic [4:0] ALUOP_SLT  = 5'b01010;
  localparam logic [4:0] ALUOP_SLTU = 5'b01011;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_COP0   = 6'h10;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FUNCT_SLL     = 6'h00;
  localparam logic [5:0] FUNCT_SRL     = 6'h02;
  localparam logic [5:0] FUNCT_SRA     = 6'h03;
  localparam logic [5:0] FUNCT_SLLV    = 6'h04;
  localparam logic [5:0] FUNCT_SRLV    = 6'h06;
  localparam logic [5:0] FUNCT_SRAV    = 6'h07;
  localparam logic [5:0] FUNCT_JR      = 6'h08;
  localparam logic [5:0] FUNCT_JALR    = 6'h09;
  localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;
  localparam logic [5:0] FUNCT_MFHI    = 6'h10;
  localparam logic [5:0] FUNCT_MTHI    = 6'h11;
  localparam logic [5:0] FUNCT_MFLO    = 6'h12;
  localparam logic [5:0] FUNCT_MTLO    = 6'h13;
  localparam logic [5:0] FUNCT_MULT    = 6'h18;
  localparam logic [5:0] FUNCT_MULTU   = 6'h19;
  localparam logic [5:0] FUNCT_DIV     = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU    = 6'h1B;
  localparam logic [5:0] FUNCT_ADD     = 6'h20;
  localparam logic [5:0] FUNCT_ADDU    = 6'h21;
  localparam logic [5:0] FUNCT_SUB     = 6'h22;
  localparam logic [5:0] FUNCT_SUBU    = 6'h23;
  localparam logic [5:0] FUNCT_AND     = 6'h24;
  localparam logic [5:0] FUNCT_OR      = 6'h25;
  localparam logic [5:0] FUNCT_XOR     = 6'h26;
  localparam logic [5:0] FUNCT_NOR     = 6'h27;
  localparam logic [5:0] FUNCT_SLT     = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU    = 6'h2B;

  typedef enum logic [1:0] {
    A_RS, A_SHAMT, A_ZERO
  } a_sel_e;

  typedef enum logic [1:0] {
    B_RT, B_SEXT, B_ZEXT, B_ZERO
  } b_sel_e;

  typedef struct packed {
    logic [4:0] aluop;
    a_sel_e     a_sel;
    b_sel_e     b_sel;
    logic       uses_alu;
    logic       ov_chk;
    logic       addr;
    logic       ri;
  } dec_t;

  typedef struct packed {
    logic [4:0]  aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid;
    logic        uses_alu;
    logic        ov_chk;
    logic        addr;
    logic        ri;
  } id_ex_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct decode into ALUop,
// operand selects and E-stage flags.
import mips_isa_pkg::*;

module alu_op_decode (
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o          = '0;
    dec_o.aluop    = ALUOP_ADD;
    dec_o.a_sel    = A_RS;
    dec_o.b_sel    = B_RT;
    dec_o.uses_alu = 1'b1;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD: dec_o.ov_chk = 1'b1;
          FUNCT_ADDU: ;
          FUNCT_SUB: begin
            dec_o.aluop  = ALUOP_SUB;
            dec_o.ov_chk = 1'b1;
          end
          FUNCT_SUBU: dec_o.aluop = ALUOP_SUB;
          FUNCT_AND:  dec_o.aluop = ALUOP_AND;
          FUNCT_OR:   dec_o.aluop = ALUOP_OR;
          FUNCT_XOR:  dec_o.aluop = ALUOP_XOR;
          FUNCT_NOR:  dec_o.aluop = ALUOP_NOR;
          FUNCT_SLT:  dec_o.aluop = ALUOP_SLT;
          FUNCT_SLTU: dec_o.aluop = ALUOP_SLTU;
          FUNCT_SLL: begin
            dec_o.aluop = ALUOP_SLL;
            dec_o.a_sel = A_SHAMT;
          end
          FUNCT_SRL: begin
            dec_o.aluop = ALUOP_SRL;
            dec_o.a_sel = A_SHAMT;
          end
          FUNCT_SRA: begin
            dec_o.aluop = ALUOP_SRA;
            dec_o.a_sel = A_SHAMT;
          end
          FUNCT_SLLV: dec_o.aluop = ALUOP_SLL;
          FUNCT_SRLV: dec_o.aluop = ALUOP_SRL;
          FUNCT_SRAV: dec_o.aluop = ALUOP_SRA;
          FUNCT_JR, FUNCT_JALR, FUNCT_SYSCALL,
          FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO,
          FUNCT_MTLO, FUNCT_MULT, FUNCT_MULTU,
          FUNCT_DIV, FUNCT_DIVU:
            dec_o.uses_alu = 1'b0;
          default: begin
            dec_o.ri       = 1'b1;
            dec_o.uses_alu = 1'b0;
            dec_o.a_sel    = A_ZERO;
            dec_o.b_sel    = B_ZERO;
          end
        endcase
      end
      OP_ADDI: begin
        dec_o.b_sel  = B_SEXT;
        dec_o.ov_chk = 1'b1;
      end
      OP_ADDIU: dec_o.b_sel = B_SEXT;
      OP_SLTI: begin
        dec_o.aluop = ALUOP_SLT;
        dec_o.b_sel = B_SEXT;
      end
      OP_SLTIU: begin
        dec_o.aluop = ALUOP_SLTU;
        dec_o.b_sel = B_SEXT;
      end
      OP_ANDI: begin
        dec_o.aluop = ALUOP_AND;
        dec_o.b_sel = B_ZEXT;
      end
      OP_ORI: begin
        dec_o.aluop = ALUOP_OR;
        dec_o.b_sel = B_ZEXT;
      end
      OP_XORI: begin
        dec_o.aluop = ALUOP_XOR;
        dec_o.b_sel = B_ZEXT;
      end
      OP_LUI: begin
        dec_o.aluop = ALUOP_LUI;
        dec_o.b_sel = B_ZEXT;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW: begin
        dec_o.b_sel = B_SEXT;
        dec_o.addr  = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
      OP_REGIMM, OP_J, OP_JAL, OP_COP0:
        dec_o.uses_alu = 1'b0;
      default: begin
        dec_o.ri       = 1'b1;
        dec_o.uses_alu = 1'b0;
        dec_o.a_sel    = A_ZERO;
        dec_o.b_sel    = B_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// D-to-E issue register: decodes the D instruction into
// ALUop and operands and holds them for the E-stage ALU.
import mips_isa_pkg::*;

module alu_issue_stage #(
  parameter int SHAMT_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic [31:0] rs_val_d,
  input  logic [31:0] rt_val_d,
  input  logic        valid_d,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [4:0]  aluop_e,
  output logic [31:0] a_e,
  output logic [31:0] b_e,
  output logic        valid_e,
  output logic        uses_alu_e,
  output logic        ov_chk_e,
  output logic        addr_e,
  output logic        ri_e
);

  dec_t        dec;
  id_ex_t      ex_d, ex_q, load;
  logic [31:0] a_val, b_val;
  logic        unused_rs_rt;

  // register-number fields are consumed by forwarding, not here
  assign unused_rs_rt = ^instr_d[25:16];

  alu_op_decode u_dec (
    .op_i    (instr_d[31:26]),
    .funct_i (instr_d[5:0]),
    .dec_o   (dec)
  );

  always_comb begin
    a_val = '0;
    unique case (dec.a_sel)
      A_RS:    a_val = rs_val_d;
      A_SHAMT: a_val = {{(32-SHAMT_W){1'b0}},
                        instr_d[6 +: SHAMT_W]};
      default: a_val = '0;
    endcase
  end

  always_comb begin
    b_val = '0;
    unique case (dec.b_sel)
      B_RT:    b_val = rt_val_d;
      B_SEXT:  b_val = {{16{instr_d[15]}}, instr_d[15:0]};
      B_ZEXT:  b_val = {16'h0000, instr_d[15:0]};
      default: b_val = '0;
    endcase
  end

  always_comb begin
    load = '0;
    if (valid_d) begin
      load.aluop    = dec.aluop;
      load.a        = a_val;
      load.b        = b_val;
      load.valid    = 1'b1;
      load.uses_alu = dec.uses_alu;
      load.ov_chk   = dec.ov_chk;
      load.addr     = dec.addr;
      load.ri       = dec.ri;
    end
  end

  always_comb begin
    ex_d = ex_q;
    if (!reset || flush_i) ex_d = '0;
    else if (!stall_i)     ex_d = load;
  end

  always_ff @(posedge clk) begin
    ex_q <= ex_d;
  end

  assign aluop_e    = ex_q.aluop;
  assign a_e        = ex_q.a;
  assign b_e        = ex_q.b;
  assign valid_e    = ex_q.valid;
  assign uses_alu_e = ex_q.uses_alu;
  assign ov_chk_e   = ex_q.ov_chk;
  assign addr_e     = ex_q.addr;
  assign ri_e       = ex_q.ri;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed ISA
// cases plus randomized traffic against a mnemonic-level model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d, rs_val_d, rt_val_d;
  logic        valid_d, stall_i, flush_i;
  logic [4:0]  aluop_e;
  logic [31:0] a_e, b_e;
  logic        valid_e, uses_alu_e, ov_chk_e, addr_e, ri_e;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk        (clk),
    .reset      (reset),
    .instr_d    (instr_d),
    .rs_val_d   (rs_val_d),
    .rt_val_d   (rt_val_d),
    .valid_d    (valid_d),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .aluop_e    (aluop_e),
    .a_e        (a_e),
    .b_e        (b_e),
    .valid_e    (valid_e),
    .uses_alu_e (uses_alu_e),
    .ov_chk_e   (ov_chk_e),
    .addr_e     (addr_e),
    .ri_e       (ri_e)
  );

  typedef enum {
    M_RI, M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV,
    M_JR, M_JALR, M_SYSCALL, M_MFHI, M_MTHI, M_MFLO,
    M_MTLO, M_MULT, M_MULTU, M_DIV, M_DIVU, M_ADD,
    M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR,
    M_SLT, M_SLTU, M_REGIMM, M_J, M_JAL, M_BEQ, M_BNE,
    M_BLEZ, M_BGTZ, M_ADDI, M_ADDIU, M_SLTI, M_SLTIU,
    M_ANDI, M_ORI, M_XORI, M_LUI, M_COP0, M_LB, M_LH,
    M_LW, M_LBU, M_LHU, M_SB, M_SH, M_SW
  } mn_t;

  typedef struct {
    logic [4:0]  aluop;
    logic [31:0] a, b;
    logic        valid, uses, ov, addr, ri;
  } exp_t;

  exp_t exp_q;

  function automatic mn_t mnem(input logic [31:0] ins);
    mn_t m;
    m = M_RI;
    if (ins[31:26] == 6'd0) begin
      case (int'(ins[5:0]))
        0: m = M_SLL;   2: m = M_SRL;   3: m = M_SRA;
        4: m = M_SLLV;  6: m = M_SRLV;  7: m = M_SRAV;
        8: m = M_JR;    9: m = M_JALR;  12: m = M_SYSCALL;
        16: m = M_MFHI; 17: m = M_MTHI; 18: m = M_MFLO;
        19: m = M_MTLO; 24: m = M_MULT; 25: m = M_MULTU;
        26: m = M_DIV;  27: m = M_DIVU; 32: m = M_ADD;
        33: m = M_ADDU; 34: m = M_SUB;  35: m = M_SUBU;
        36: m = M_AND;  37: m = M_OR;   38: m = M_XOR;
        39: m = M_NOR;  42: m = M_SLT;  43: m = M_SLTU;
        default: m = M_RI;
      endcase
    end else begin
      case (int'(ins[31:26]))
        1: m = M_REGIMM; 2: m = M_J;      3: m = M_JAL;
        4: m = M_BEQ;    5: m = M_BNE;    6: m = M_BLEZ;
        7: m = M_BGTZ;   8: m = M_ADDI;   9: m = M_ADDIU;
        10: m = M_SLTI;  11: m = M_SLTIU; 12: m = M_ANDI;
        13: m = M_ORI;   14: m = M_XORI;  15: m = M_LUI;
        16: m = M_COP0;  32: m = M_LB;    33: m = M_LH;
        35: m = M_LW;    36: m = M_LBU;   37: m = M_LHU;
        40: m = M_SB;    41: m = M_SH;    43: m = M_SW;
        default: m = M_RI;
      endcase
    end
    return m;
  endfunction

  function automatic exp_t model(input logic [31:0] ins,
                                 input logic [31:0] rs, rt,
                                 input logic v);
    exp_t e;
    mn_t  m;
    logic [31:0] sx, zx;
    e = '{default: '0};
    if (!v) return e;
    m  = mnem(ins);
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    e.valid = 1'b1;
    e.aluop = 5'd1;
    e.a = rs;
    e.b = rt;
    e.uses = 1'b1;
    case (m)
      M_ADD, M_ADDU: e.aluop = 5'd1;
      M_SUB, M_SUBU: e.aluop = 5'd2;
      M_AND: e.aluop = 5'd8;
      M_OR:  e.aluop = 5'd0;
      M_XOR: e.aluop = 5'd5;
      M_NOR: e.aluop = 5'd9;
      M_SLT: e.aluop = 5'd10;
      M_SLTU: e.aluop = 5'd11;
      M_SLL: begin e.aluop = 5'd4; e.a = 32'(ins[10:6]); end
      M_SRL: begin e.aluop = 5'd6; e.a = 32'(ins[10:6]); end
      M_SRA: begin e.aluop = 5'd7; e.a = 32'(ins[10:6]); end
      M_SLLV: e.aluop = 5'd4;
      M_SRLV: e.aluop = 5'd6;
      M_SRAV: e.aluop = 5'd7;
      M_ADDI, M_ADDIU: e.b = sx;
      M_SLTI:  begin e.aluop = 5'd10; e.b = sx; end
      M_SLTIU: begin e.aluop = 5'd11; e.b = sx; end
      M_ANDI:  begin e.aluop = 5'd8;  e.b = zx; end
      M_ORI:   begin e.aluop = 5'd0;  e.b = zx; end
      M_XORI:  begin e.aluop = 5'd5;  e.b = zx; end
      M_LUI:   begin e.aluop = 5'd3;  e.b = zx; end
      M_LB, M_LH, M_LW, M_LBU, M_LHU, M_SB, M_SH, M_SW:
        begin e.b = sx; e.addr = 1'b1; end
      M_RI: begin
        e.ri = 1'b1; e.uses = 1'b0; e.a = '0; e.b = '0;
      end
      default: e.uses = 1'b0;
    endcase
    e.ov = (m == M_ADD) || (m == M_ADDI) || (m == M_SUB);
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".aluop"}, 32'(aluop_e), 32'(exp_q.aluop));
    chk({tag, ".a"}, a_e, exp_q.a);
    chk({tag, ".b"}, b_e, exp_q.b);
    chk({tag, ".valid"}, 32'(valid_e), 32'(exp_q.valid));
    chk({tag, ".uses"}, 32'(uses_alu_e), 32'(exp_q.uses));
    chk({tag, ".ov"}, 32'(ov_chk_e), 32'(exp_q.ov));
    chk({tag, ".addr"}, 32'(addr_e), 32'(exp_q.addr));
    chk({tag, ".ri"}, 32'(ri_e), 32'(exp_q.ri));
  endtask

  task automatic step(input string tag, input logic [31:0] ins,
                      input logic [31:0] rs, rt,
                      input logic v, st, fl, rst);
    @(negedge clk);
    instr_d = ins; rs_val_d = rs; rt_val_d = rt;
    valid_d = v; stall_i = st; flush_i = fl; reset = rst;
    @(posedge clk);
    if (!rst || fl) exp_q = '{default: '0};
    else if (!st)   exp_q = model(ins, rs, rt, v);
    #1;
    chk_all(tag);
  endtask

  initial begin
    logic [31:0] ins;
    logic [5:0]  ops [26];
    exp_q = '{default: '0};
    ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
            6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
            6'h0E, 6'h0F, 6'h10, 6'h20, 6'h21, 6'h23, 6'h24,
            6'h25, 6'h28, 6'h29, 6'h2B, 6'h3F};

    step("rst0", 32'h00221821, 1, 2, 1, 0, 0, 0);
    step("rst1", 32'h00221821, 1, 2, 1, 0, 0, 0);
    chk("rst_valid", 32'(valid_e), 0);
    chk("rst_aluop", 32'(aluop_e), 0);

    step("addu", 32'h00221821, 5, 7, 1, 0, 0, 1);
    chk("addu_op", 32'(aluop_e), 1);
    chk("addu_a", a_e, 5);
    chk("addu_b", b_e, 7);
    chk("addu_uses", 32'(uses_alu_e), 1);

    step("sra", 32'h00021903, 0, 32'h80000000, 1, 0, 0, 1);
    chk("sra_op", 32'(aluop_e), 7);
    chk("sra_a", a_e, 4);
    chk("sra_b", b_e, 32'h80000000);

    step("addi", 32'h2001FFFF, 0, 3, 1, 0, 0, 1);
    chk("addi_b", b_e, 32'hFFFFFFFF);
    chk("addi_ov", 32'(ov_chk_e), 1);
    step("ori", 32'h3401FFFF, 0, 3, 1, 0, 0, 1);
    chk("ori_b", b_e, 32'h0000FFFF);
    chk("ori_op", 32'(aluop_e), 0);

    step("lw", 32'h8FA2FFFC, 32'h1000, 0, 1, 0, 0, 1);
    chk("lw_op", 32'(aluop_e), 1);
    chk("lw_b", b_e, 32'hFFFFFFFC);
    chk("lw_addr", 32'(addr_e), 1);
    chk("lw_ov", 32'(ov_chk_e), 0);

    step("op3f", 32'hFC000000, 9, 9, 1, 0, 0, 1);
    chk("op3f_ri", 32'(ri_e), 1);
    chk("op3f_uses", 32'(uses_alu_e), 0);

    step("nop", 32'h00000000, 1, 32'h1234, 1, 0, 0, 1);
    chk("nop_op", 32'(aluop_e), 4);
    chk("nop_a", a_e, 0);
    chk("nop_b", b_e, 32'h1234);

    step("ld_addu", 32'h00221821, 5, 7, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step("stall", $urandom, $urandom, $urandom, 1, 1, 0, 1);
      chk("stall_a", a_e, 5);
      chk("stall_b", b_e, 7);
      chk("stall_valid", 32'(valid_e), 1);
    end
    step("st_fl", 32'h00221821, 5, 7, 1, 1, 1, 1);
    chk("stfl_valid", 32'(valid_e), 0);
    chk("stfl_a", a_e, 0);

    step("ld_ori", 32'h3401FFFF, 0, 0, 1, 0, 0, 1);
    step("rst_st", 32'h00221821, 5, 7, 1, 1, 0, 0);
    chk("rstst_valid", 32'(valid_e), 0);
    chk("rstst_b", b_e, 0);
    step("resume", 32'h00221821, 9, 11, 1, 0, 0, 1);
    chk("resume_a", a_e, 9);
    chk("resume_valid", 32'(valid_e), 1);

    step("inval", 32'h00221821, 9, 11, 0, 0, 0, 1);
    chk("inval_valid", 32'(valid_e), 0);

    for (int i = 0; i < 1500; i++) begin
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 25)];
      step("rand", ins, $urandom, $urandom,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 29) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
